// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared types and constants for the I2C memory target.
// State encoding is exported on slave_state for bus-level assertions.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE_S   = 3'd0,
        RCV_ADDR = 3'd1,
        ADDR_ACK = 3'd2,
        WRITE    = 3'd3,
        DATA_ACK = 3'd4,
        READ     = 3'd5,
        READ_ACK = 3'd6,
        STOP_S   = 3'd7
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;
    localparam int         MEM_DEPTH        = 128;
    localparam int         PTR_W            = $clog2(MEM_DEPTH);

endpackage

// File: rtl/i2c_mem_slave_if.sv
// i2c_mem_slave_if: open-drain I2C pin bundle between initiator and target.
// sda_in is the resolved wired-AND level seen on the bus.
interface i2c_mem_slave_if;

    logic scl;
    logic sda_in;
    logic sda_oe;

    modport master (
        output scl,
        output sda_in,
        input  sda_oe
    );

    modport slave (
        input  scl,
        input  sda_in,
        output sda_oe
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop synchronizers on SCL/SDA plus an edge register.
// Produces SCL edges and START/STOP conditions three cycles after the pins.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_q, scl_meta_d;
    logic scl_sync_q, scl_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_meta_q, sda_meta_d;
    logic sda_sync_q, sda_sync_d;
    logic sda_prev_q, sda_prev_d;

    always_comb begin
        scl_meta_d = scl_pin;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = sda_pin;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // SDA edges only count as conditions while SCL is stably high
    assign sda       = sda_sync_q;
    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/i2c_mem_slave.sv
// i2c_mem_slave: I2C target fronting a 128x8 memory with a wrapping pointer.
// Optional host access port is enabled by defining I2C_SLAVE_HOST_PORT_EN.
module i2c_mem_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int         MIN_HALF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_mem_slave_if.slave   bus,
`ifdef I2C_SLAVE_HOST_PORT_EN
    input  logic [PTR_W-1:0] host_raddr,
    output logic [7:0]       host_rdata,
    input  logic             host_we,
    input  logic [7:0]       host_wdata,
`endif
    output logic             busy,
    output logic             wr_pulse,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [2:0]       slave_state
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_pin   (bus.scl),
        .sda_pin   (bus.sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             first_q, first_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [3:0]       phase_q, phase_d;

    logic [7:0]       mem_q [MEM_DEPTH];
    logic             mem_we;
    logic [7:0]       mem_wdata;

    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc;
    logic             byte_done;
    logic             addr_hit;

    assign rx_byte   = {shift_q[6:0], sda};
    assign ptr_inc   = ptr_q + 7'd1;
    assign byte_done = (bit_cnt_q == 4'd8);
    assign addr_hit  = (shift_q[7:1] == DEV_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_S;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            phase_q    <= 4'hF;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            phase_q    <= phase_d;
            if (scl_rise || scl_fall) begin
                assert (int'(phase_q) >= MIN_HALF - 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = RCV_ADDR;
        end else if (stop_det) begin
            state_d = STOP_S;
        end else begin
            unique case (state_q)
                STOP_S:   state_d = IDLE_S;
                RCV_ADDR: if (scl_fall && byte_done)
                              state_d = addr_hit ? ADDR_ACK : IDLE_S;
                ADDR_ACK: if (scl_fall)
                              state_d = shift_q[0] ? WRITE : READ;
                WRITE:    if (scl_fall && byte_done) state_d = DATA_ACK;
                DATA_ACK: if (scl_fall) state_d = WRITE;
                READ:     if (scl_fall && byte_done) state_d = READ_ACK;
                READ_ACK: if (scl_rise) state_d = sda ? IDLE_S : READ;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        first_d    = first_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        mem_wdata  = rx_byte;
        if (scl_rise || scl_fall) begin
            phase_d = 4'd0;
        end else begin
            phase_d = (phase_q == 4'hF) ? phase_q : phase_q + 4'd1;
        end
        if (start_det) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                RCV_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = addr_hit;
                        busy_d    = addr_hit;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            sda_oe_d  = 1'b0;
                            first_d   = 1'b1;
                            bit_cnt_d = 4'd0;
                        end else begin
                            // MSB goes out on this same fall that ends the ACK
                            sda_oe_d  = ~mem_q[ptr_q][7];
                            shift_d   = {mem_q[ptr_q][6:0], 1'b0};
                            bit_cnt_d = 4'd1;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (first_q) begin
                                first_d = 1'b0;
                                ptr_d   = rx_byte[6:0];
                            end else begin
                                mem_we     = 1'b1;
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_inc;
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                READ: begin
                    if (scl_fall) begin
                        if (byte_done) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        sda_oe_d = 1'b0;
                        if (!sda) begin
                            ptr_d     = ptr_inc;
                            shift_d   = mem_q[ptr_inc];
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
`ifdef I2C_SLAVE_HOST_PORT_EN
        else if (host_we && !busy_q) begin
            mem_q[host_raddr] <= host_wdata;
        end
`endif
    end

`ifdef I2C_SLAVE_HOST_PORT_EN
    assign host_rdata = mem_q[host_raddr];
`endif

    assign bus.sda_oe  = sda_oe_q;
    assign busy        = busy_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign slave_state = state_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// tb_i2c_mem_slave: directed I2C transactions against i2c_mem_slave.
// Host-port checks are built only when I2C_SLAVE_HOST_PORT_EN is defined.
module tb_i2c_mem_slave;
    import i2c_slave_pkg::*;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic busy, wr_pulse;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] slave_state;
`ifdef I2C_SLAVE_HOST_PORT_EN
    logic [6:0] host_raddr = 7'd0;
    logic [7:0] host_rdata;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = 8'd0;
`endif

    always #5 clk = ~clk;

    i2c_mem_slave_if bus ();
    assign bus.scl    = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_mem_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
`ifdef I2C_SLAVE_HOST_PORT_EN
        .host_raddr  (host_raddr),
        .host_rdata  (host_rdata),
        .host_we     (host_we),
        .host_wdata  (host_wdata),
`endif
        .busy        (busy),
        .wr_pulse    (wr_pulse),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .slave_state (slave_state)
    );

    int checks = 0;
    int errors = 0;
    logic [14:0] wq[$];

    always @(negedge clk) begin
        if (wr_pulse) wq.push_back({wr_addr, wr_data});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        tick(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        tick(2);
        sda_m = 1'b1;
        tick(H - 2);
        scl_m = 1'b1;
        tick(H);
        sda_m = 1'b0;
        tick(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(2);
        sda_m = 1'b0;
        tick(H - 2);
        scl_m = 1'b1;
        tick(H);
        sda_m = 1'b1;
        tick(H);
    endtask

    task automatic send_bit(input logic b);
        tick(2);
        sda_m = b;
        tick(H - 2);
        scl_m = 1'b1;
        tick(H);
        scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(2);
        sda_m = 1'b1;
        tick(H - 2);
        scl_m = 1'b1;
        tick(H / 2);
        b = bus.sda_in;
        tick(H / 2);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic [7:0] r;
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bt);
            r[i] = bt;
        end
        send_bit(nack);
        d = r;
    endtask

    task automatic chk_wr(input string tag, input logic [6:0] a,
                          input logic [7:0] d);
        logic [14:0] e;
        if (wq.size() > 0) e = wq.pop_front();
        else e = '1;
        chk(tag, e, {a, d});
    endtask

    logic       ack;
    logic [7:0] rb;
    logic [2:0] b3;
    logic       bt;

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk("rst_oe", bus.sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrp", wr_pulse, 0);
        chk("rst_wra", wr_addr, 0);
        chk("rst_wrd", wr_data, 0);
        chk("rst_st", slave_state, IDLE_S);
        chk("rst_ptr", dut.ptr_q, 0);

        // write 0x5A, 0xC3 starting at 0x10
        i2c_start();
        send_byte(8'hA1, ack);
        chk("w_aack", ack, 0);
        chk("w_busy", busy, 1);
        send_byte(8'h10, ack);
        chk("w_ack0", ack, 0);
        send_byte(8'h5A, ack);
        chk("w_ack1", ack, 0);
        send_byte(8'hC3, ack);
        chk("w_ack2", ack, 0);
        i2c_stop();
        chk("w_nwr", wq.size(), 2);
        chk_wr("w_wr0", 7'h10, 8'h5A);
        chk_wr("w_wr1", 7'h11, 8'hC3);
        chk("w_ptr", dut.ptr_q, 7'h12);
        chk("w_busy0", busy, 0);
        chk("w_st", slave_state, IDLE_S);

        // pointer write, repeated START, read two bytes
        i2c_start();
        send_byte(8'hA1, ack);
        send_byte(8'h10, ack);
        chk("r_pack", ack, 0);
        i2c_rstart();
        send_byte(8'hA0, ack);
        chk("r_aack", ack, 0);
        recv_byte(rb, 1'b0);
        chk("r_b0", rb, 8'h5A);
        recv_byte(rb, 1'b1);
        chk("r_b1", rb, 8'hC3);
        tick(5);
        chk("r_oe", bus.sda_oe, 0);
        chk("r_busy", busy, 1);
        chk("r_st", slave_state, IDLE_S);
        i2c_stop();
        chk("r_busy0", busy, 0);
        chk("r_nwr", wq.size(), 0);
        chk("r_ptr", dut.ptr_q, 7'h11);

        // wrong device address
        i2c_start();
        send_byte(8'h9F, ack);
        chk("m_ack", ack, 1);
        chk("m_oe", bus.sda_oe, 0);
        chk("m_busy", busy, 0);
        chk("m_st", slave_state, IDLE_S);
        i2c_stop();
        chk("m_nwr", wq.size(), 0);

        // pointer wrap on write and read
        i2c_start();
        send_byte(8'hA1, ack);
        send_byte(8'h7F, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        chk("x_ack", ack, 0);
        i2c_stop();
        chk("x_nwr", wq.size(), 2);
        chk_wr("x_wr0", 7'h7F, 8'h11);
        chk_wr("x_wr1", 7'h00, 8'h22);
        chk("x_ptr", dut.ptr_q, 7'h01);
        i2c_start();
        send_byte(8'hA1, ack);
        send_byte(8'h7F, ack);
        i2c_rstart();
        send_byte(8'hA0, ack);
        recv_byte(rb, 1'b0);
        chk("x_rb0", rb, 8'h11);
        recv_byte(rb, 1'b1);
        chk("x_rb1", rb, 8'h22);
        i2c_stop();
        chk("x_rptr", dut.ptr_q, 7'h00);

        // reset during bit 4 of a read of mem[0] = 0x22
        i2c_start();
        send_byte(8'hA1, ack);
        send_byte(8'h00, ack);
        i2c_rstart();
        send_byte(8'hA0, ack);
        for (int i = 2; i >= 0; i--) begin
            recv_bit(bt);
            b3[i] = bt;
        end
        chk("z_bits", b3, 3'b001);
        tick(2);
        sda_m = 1'b1;
        tick(H - 2);
        chk("z_oe1", bus.sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("z_oe0", bus.sda_oe, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        chk("z_st", slave_state, IDLE_S);
        chk("z_ptr", dut.ptr_q, 0);
        chk("z_busy", busy, 0);

`ifdef I2C_SLAVE_HOST_PORT_EN
        host_raddr = 7'h20;
        host_wdata = 8'hEE;
        host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        chk("h_rd", host_rdata, 8'hEE);
        i2c_start();
        send_byte(8'hA1, ack);
        send_byte(8'h20, ack);
        i2c_rstart();
        send_byte(8'hA0, ack);
        recv_byte(rb, 1'b1);
        chk("h_i2c", rb, 8'hEE);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, ack);
        chk("h_busy", busy, 1);
        host_wdata = 8'h33;
        host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        chk("h_drop", host_rdata, 8'hEE);
        i2c_stop();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_mem_slave.md
Name: i2c_mem_slave

Overview:
- Synthesizable I2C responder (target) fronting a 128 x 8 byte memory.
- Oversamples the bus on the system clock, detects START/STOP, matches its 7-bit device address and ACKs address and write bytes.
- Writes bytes into memory through an auto-incrementing word pointer; returns read bytes from the same pointer until the initiator NACKs.
- Sits at the far end of the bus from the team's I2C master and drives SDA open-drain only.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address answered by this target.
- MIN_HALF, 4, minimum SCL high/low width in clk cycles guaranteed by the initiator (documentation/checker use only).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- scl  input  1  bus SCL (target never stretches).
- sda_in  input  1  resolved bus SDA.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- busy  output  1  high from a START that addresses this target until STOP or address mismatch.
- wr_pulse  output  1  one-cycle strobe when a data byte is committed to memory.
- wr_addr  output  7  memory index of the committed byte.
- wr_data  output  8  committed byte.
- slave_state  output  3  encoded current state, for assertions.

Behaviour:
- Reset: sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, state IDLE_S, pointer=0, bit counter=0, synchronizers=1. Memory is not cleared.
- Input conditioning: scl and sda_in pass through 2-flop synchronizers, then a registered copy for edge detection. Decisions lag the pins by 3 cycles.
- scl_rise/scl_fall are derived from the synchronized SCL.
  - START = synchronized SDA falls while SCL high.
  - STOP = synchronized SDA rises while SCL high.
- Data is sampled on scl_rise. sda_oe changes only on scl_fall, so SDA is never altered while SCL is high.
- States: IDLE_S, RCV_ADDR, ADDR_ACK, WRITE, DATA_ACK, READ, READ_ACK, STOP_S.
  - Any state + START -> RCV_ADDR, bit count 0, sda_oe=0. This covers repeated START.
  - Any state + STOP -> STOP_S, then IDLE_S next cycle; busy=0, sda_oe=0.
  - RCV_ADDR: shift in MSB first, 8 bits (7 address + R/W). Bus R/W bit 1 = write, 0 = read, matching the master's rw convention.
    - Match: on the 8th scl_fall, drive sda_oe=1 -> ADDR_ACK, busy=1.
    - Mismatch: IDLE_S, sda_oe stays 0.
  - ADDR_ACK: on the next scl_fall release.
    - Write: -> WRITE; first-byte flag set.
    - Read: -> READ; load mem[pointer] into the shift register and drive its MSB.
  - WRITE: shift in 8 bits; on the 8th scl_fall drive ACK -> DATA_ACK.
    - First byte after the address: pointer <= byte[6:0] (bit 7 ignored); no memory write; no wr_pulse.
    - Later bytes: mem[pointer] <= byte, wr_pulse with wr_addr=pointer, wr_data=byte, then pointer+1.
    - Write and strobe occur on the scl_rise of bit 8.
  - DATA_ACK: on scl_fall release -> WRITE.
  - READ: on each scl_fall drive sda_oe = ~shift[7] and shift left. After 8 bits release -> READ_ACK.
  - READ_ACK: sample on scl_rise.
    - 0 (ACK): pointer+1, reload -> READ.
    - 1 (NACK): -> IDLE_S with sda_oe=0, awaiting STOP. busy stays 1 until STOP.
- Pointer arithmetic is 7-bit, wrapping 127 -> 0 for both read and write.
- The pointer persists across transactions; only reset zeroes it. This allows write-pointer-then-repeated-START-read.
- Reset asserted mid-transfer releases SDA immediately (asynchronous).

Optional Feature:
- Macro I2C_SLAVE_HOST_PORT_EN.
- When defined:
  - Adds ports host_raddr (input, 7) and host_rdata (output, 8); host_rdata = mem[host_raddr] combinationally.
  - Adds host_we (input, 1), host_wdata (input, 8), which write mem[host_raddr] on posedge clk when busy=0.
  - Host writes while busy=1 are dropped.
- When undefined: the ports are absent and memory is reachable only over I2C.

Decomposition:
- Package i2c_slave_pkg: typedef enum logic [2:0] state_t with the eight states above, DEFAULT_DEV_ADDR, MEM_DEPTH=128.
- One sub-module, i2c_bus_sync: both 2-flop synchronizers, edge register, and the scl_rise, scl_fall, start_det, stop_det outputs.
- Byte FSM, shift register, pointer and memory stay in i2c_mem_slave.

Test Plan:
- START, 0xA1 (addr 0x50, R/W=1), 0x10, 0x5A, 0xC3, STOP -> ACK on all three data-phase bytes. Expect:
  - wr_pulse (0x10, 0x5A)
  - wr_pulse (0x11, 0xC3)
  - pointer 0x12, busy low after STOP.
- Write pointer 0x10, repeated START, 0xA0 (read), ACK, NACK -> target drives 0x5A then 0xC3; sda_oe=0 after NACK. busy falls on STOP.
- START, 0x9F (addr 0x4F) -> no ACK (sda_oe stays 0), state IDLE_S, no wr_pulse, busy=0.
- Pointer 0x7F, write 0x11, 0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22 (wrap).
- Assert rst_n low during bit 4 of a read byte -> sda_oe=0 within the same cycle; after release state IDLE_S, pointer 0.
- With I2C_SLAVE_HOST_PORT_EN: host writes mem[0x20]=0xEE while idle; I2C read at 0x20 returns 0xEE. A host write during busy=1 leaves memory unchanged.
